sst_seq: RTL and testbench
==========================

Name: sst_seq

Overview:
Save-state sequencer that sits directly upstream of a mapper's save-state register port. It drives the mapper's sst act/addr/we_reg/dato signals and collects sst_di.
- On a save command, it walks the mapper register window and streams each byte out, followed by a map-index trailer.
- On a load command, it checks a map-index header, then writes a streamed image back into the mapper registers.
- It serves mappers that expose registers at sst addresses 0..REG_CNT-1 and the map index at address 127.

Parameters:
REG_CNT, 16, number of mapper state bytes at sst addresses 0..REG_CNT-1 (1..127)
IDX_ADDR, 127, sst address that returns cfg.map_idx

Ports:
m2  in  1  clock; all state updates on negedge m2, the same edge the mapper uses
map_rst  in  1  synchronous reset, active-high
cmd_save  in  1  start save; sampled in IDLE only
cmd_load  in  1  start load; sampled in IDLE only
map_idx  in  8  expected mapper index (cfg.map_idx)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when an operation ends (ok or error)
err  out  1  sticky load-header mismatch flag
sst_act  out  1  to mapper sst.act
sst_we_reg  out  1  to mapper sst.we_reg
sst_addr  out  8  to mapper sst.addr
sst_dato  out  8  to mapper sst.dato
sst_di  in  8  from mapper sst_di (combinational in the mapper)
rd_data  out  8  save stream data
rd_valid  out  1  save stream valid
rd_ready  in  1  save stream ready
wr_data  in  8  load stream data
wr_valid  in  1  load stream valid
wr_ready  out  1  load stream ready

Behaviour:
- Reset: state IDLE; addr counter 0. All outputs 0: busy, done, err, sst_act, sst_we_reg, sst_addr, sst_dato, rd_data, rd_valid, wr_ready.
- Reset mid-operation: the next edge returns to IDLE with all outputs 0. No done pulse.
- States: IDLE, SV_ADDR, SV_OUT, LD_HDR, LD_WAIT, LD_WR, FIN.
- IDLE:
  - cmd_save goes to SV_ADDR with cnt=0.
  - Otherwise cmd_load goes to LD_HDR.
  - Both asserted in the same cycle: save wins.
  - Accepting either command clears err.
  - Commands outside IDLE are ignored.
- sst_act is 1 in every state except IDLE and FIN.
- sst_addr:
  - equals cnt for cnt<REG_CNT;
  - equals IDX_ADDR when cnt==REG_CNT (save only).
- SV_ADDR: drives sst_addr for one cycle (mapper settle). Next edge: rd_data<=sst_di, rd_valid<=1, go to SV_OUT.
- SV_OUT: rd_valid and rd_data are held stable until rd_ready is seen at an edge. On that edge rd_valid<=0, and then:
  - if cnt==REG_CNT, go to FIN;
  - else cnt<=cnt+1 and go to SV_ADDR.
- Save output: REG_CNT+1 bytes in address order, index byte last.
- Save throughput: 2 cycles/byte with rd_ready tied high.
- sst_we_reg is never asserted during a save.
- LD_HDR:
  - wr_ready=1.
  - On a wr_valid&wr_ready edge with wr_data==map_idx: cnt<=0, go to LD_WAIT.
  - On mismatch: err<=1, go to FIN with no register writes.
- LD_WAIT: wr_ready=1. On a handshake edge: sst_dato<=wr_data, go to LD_WR.
- LD_WR:
  - wr_ready=0; sst_we_reg=1 for exactly this one cycle, with sst_addr=cnt.
  - Then if cnt==REG_CNT-1 go to FIN; else cnt<=cnt+1 and go to LD_WAIT.
- Load consumes exactly 1+REG_CNT bytes. wr_ready is 0 outside LD_HDR and LD_WAIT.
- FIN: done=1 for one cycle; sst_act=0; go to IDLE.
- cnt width is 8 bits. It never exceeds REG_CNT, so there is no wrap.

Test Plan:
- Save, REG_CNT=16, mapper model with reg k = 8'hA0+k and map_idx=65, rd_ready=1 -> 17 bytes A0..AF then 8'h41. done pulses once. Exactly 34 cycles from SV_ADDR entry to FIN. sst_we_reg stays 0 throughout.
- Save with rd_ready toggled pseudo-randomly -> same 17-byte sequence. rd_data is stable whenever rd_valid=1 and rd_ready=0. No byte duplicated or lost.
- Load with header 8'h41, then bytes 00..0F -> 16 sst_we_reg pulses at addrs 0..15 with dato equal to each addr. Mapper registers match. err=0; done pulses once.
- Load with header 8'h42 while map_idx=65 -> err=1, done pulses, zero sst_we_reg pulses, wr_ready=0 after the header. The next cmd_save clears err.
- cmd_save and cmd_load in the same cycle -> a save runs. A further cmd_load during busy has no effect.
- map_rst during the 5th load byte -> the next edge gives sst_act=0, busy=0, wr_ready=0, no done. A new cmd_save then completes normally.

Source files
------------

// File: rtl/sst_seq.sv
// Save-state sequencer: streams mapper registers plus a map-index trailer out on save,
// and verifies a map-index header then writes the streamed image back on load.
module sst_seq #(
  parameter int REG_CNT  = 16,
  parameter int IDX_ADDR = 127
) (
  input  logic       m2,
  input  logic       map_rst,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic [7:0] map_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sst_act,
  output logic       sst_we_reg,
  output logic [7:0] sst_addr,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready
);

  typedef enum logic [2:0] {
    IDLE, SV_ADDR, SV_OUT, LD_HDR, LD_WAIT, LD_WR, FIN
  } state_t;

  localparam logic [7:0] CNT_IDX  = 8'(REG_CNT);
  localparam logic [7:0] CNT_LAST = 8'(REG_CNT - 1);
  localparam logic [7:0] ADDR_IDX = 8'(IDX_ADDR);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] dato_q, dato_d;
  logic       busy_q, done_q, act_q, we_q, rd_valid_q, wr_ready_q;
  logic [7:0] addr_q;
  logic       act_d;
  logic [7:0] addr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    dato_d    = dato_q;
    case (state_q)
      IDLE: begin
        if (cmd_save) begin
          state_d = SV_ADDR;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end else if (cmd_load) begin
          state_d = LD_HDR;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      SV_ADDR: begin
        rd_data_d = sst_di;
        state_d   = SV_OUT;
      end
      SV_OUT: begin
        if (rd_ready) begin
          if (cnt_q == CNT_IDX) begin
            state_d = FIN;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = SV_ADDR;
          end
        end
      end
      LD_HDR: begin
        if (wr_valid && wr_ready_q) begin
          if (wr_data == map_idx) begin
            cnt_d   = 8'd0;
            state_d = LD_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      LD_WAIT: begin
        if (wr_valid && wr_ready_q) begin
          dato_d  = wr_data;
          state_d = LD_WR;
        end
      end
      LD_WR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = LD_WAIT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the register with it.
  always_comb begin
    act_d  = (state_d != IDLE) && (state_d != FIN);
    addr_d = 8'd0;
    if (act_d) addr_d = (cnt_d == CNT_IDX) ? ADDR_IDX : cnt_d;
  end

  always_ff @(negedge m2) begin
    if (map_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      rd_data_q  <= 8'd0;
      dato_q     <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      act_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 8'd0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      dato_q     <= dato_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == FIN);
      act_q      <= act_d;
      we_q       <= (state_d == LD_WR);
      addr_q     <= addr_d;
      rd_valid_q <= (state_d == SV_OUT);
      wr_ready_q <= (state_d == LD_HDR) || (state_d == LD_WAIT);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sst_act    = act_q;
  assign sst_we_reg = we_q;
  assign sst_addr   = addr_q;
  assign sst_dato   = dato_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_sst_seq.sv
// Bench for sst_seq: mapper model, randomized save/load traffic and a per-cycle scoreboard.
module tb_sst_seq;
  localparam int R = 16;

  logic       m2 = 1'b0;
  logic       map_rst, cmd_save, cmd_load;
  logic [7:0] map_idx;
  logic       busy, done, err, sst_act, sst_we_reg;
  logic [7:0] sst_addr, sst_dato, sst_di, rd_data;
  logic       rd_valid, rd_ready;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;

  always #5 m2 = ~m2;

  sst_seq #(.REG_CNT(R), .IDX_ADDR(127)) dut (
    .m2(m2), .map_rst(map_rst), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .map_idx(map_idx), .busy(busy), .done(done), .err(err),
    .sst_act(sst_act), .sst_we_reg(sst_we_reg), .sst_addr(sst_addr),
    .sst_dato(sst_dato), .sst_di(sst_di), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready)
  );

  // Mapper: registers at 0..R-1, map index at 127, writes on the shared edge.
  logic [7:0] mreg [R];
  assign sst_di = (sst_addr == 8'd127) ? map_idx :
                  (sst_addr < 8'(R)) ? mreg[sst_addr[3:0]] : 8'h00;
  always @(negedge m2) if (sst_we_reg && sst_addr < 8'(R)) mreg[sst_addr[3:0]] <= sst_dato;

  int errors = 0;
  int checks = 0;
  logic [7:0]  model_reg [R];
  logic [7:0]  exp_sv [$];
  logic [7:0]  got_sv [$];
  logic [15:0] exp_wr [$];
  int          done_cnt = 0;
  int          we_cnt   = 0;
  bit          in_save  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge m2);
    #1;
  endtask

  // Scoreboard: samples between edges, sees this cycle's outputs and the inputs for the next edge.
  initial begin
    logic p_valid, p_ready, p_done;
    logic [7:0] p_data;
    p_valid = 0; p_ready = 0; p_done = 0; p_data = 0;
    forever begin
      @(posedge m2);
      #2;
      if (rd_valid && rd_ready) begin
        chk("sv_queue_nonempty", 32'(exp_sv.size() > 0), 1);
        if (exp_sv.size() > 0) chk("sv_byte", 32'(rd_data), 32'(exp_sv.pop_front()));
        got_sv.push_back(rd_data);
      end
      if (p_valid && !p_ready && !map_rst) begin
        chk("sv_hold_valid", 32'(rd_valid), 1);
        chk("sv_hold_data", 32'(rd_data), 32'(p_data));
      end
      if (sst_we_reg) begin
        we_cnt++;
        chk("we_act", 32'(sst_act), 1);
        chk("we_in_save", 32'(in_save), 0);
        chk("wr_queue_nonempty", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) chk("wr_addr_dato", 32'({sst_addr, sst_dato}), 32'(exp_wr.pop_front()));
      end
      if (done) begin
        done_cnt++;
        chk("done_one_cycle", 32'(p_done), 0);
        chk("done_act", 32'(sst_act), 0);
      end
      if (!busy) begin
        chk("idle_act", 32'(sst_act), 0);
        chk("idle_wr_ready", 32'(wr_ready), 0);
        chk("idle_rd_valid", 32'(rd_valid), 0);
      end
      if (in_save) chk("save_wr_ready", 32'(wr_ready), 0);
      p_valid = rd_valid; p_ready = rd_ready; p_data = rd_data; p_done = done;
    end
  end

  task automatic run_save(input bit rnd, input bit both, input bit poke_load, input bit exp34);
    int n;
    int d0;
    cyc();
    for (int k = 0; k < R; k++) exp_sv.push_back(model_reg[k]);
    exp_sv.push_back(map_idx);
    got_sv.delete();
    d0 = done_cnt;
    in_save = 1'b1;
    cmd_save = 1'b1;
    cmd_load = both;
    rd_ready = 1'b1;
    cyc();
    cmd_save = 1'b0;
    cmd_load = 1'b0;
    chk("save_busy", 32'(busy), 1);
    chk("save_err_clr", 32'(err), 0);
    n = 0;
    while (!done && n < 2000) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cmd_load = (poke_load && n == 5);
      cyc();
      n++;
    end
    cmd_load = 1'b0;
    chk("save_timeout", 32'(n < 2000), 1);
    if (exp34) chk("save_cycles", 32'(n), 34);
    cyc();
    cyc();
    in_save = 1'b0;
    chk("save_done_once", 32'(done_cnt - d0), 1);
    chk("save_all_bytes", 32'(exp_sv.size()), 0);
    chk("save_byte_count", 32'(got_sv.size()), R + 1);
    chk("save_idle_after", 32'(busy), 0);
    exp_sv.delete();
  endtask

  task automatic run_load(input logic [7:0] hdr, input bit rnd, input int rst_idx);
    logic [7:0] data [R];
    bit good;
    bit wv;
    bit take;
    int i, n, d0, w0;
    good = (hdr == map_idx);
    for (int k = 0; k < R; k++) data[k] = rnd ? 8'($urandom_range(0, 255)) : 8'(k);
    if (good) for (int k = 0; k < R; k++) exp_wr.push_back({8'(k), data[k]});
    d0 = done_cnt;
    w0 = we_cnt;
    cyc();
    cmd_load = 1'b1;
    cyc();
    cmd_load = 1'b0;
    chk("load_busy", 32'(busy), 1);
    i = 0;
    n = 0;
    while (!done && n < 2000) begin
      if (i == rst_idx && wr_ready) begin
        map_rst  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = data[i - 1];
        cyc();
        map_rst  = 1'b0;
        wr_valid = 1'b0;
        chk("rst_act", 32'(sst_act), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_done", 32'(done), 0);
        repeat (3) cyc();
        chk("rst_no_done", 32'(done_cnt - d0), 0);
        chk("rst_writes_left", 32'(exp_wr.size()), 32'(R - (rst_idx - 1)));
        for (int k = 0; k < rst_idx - 1; k++) model_reg[k] = data[k];
        exp_wr.delete();
        return;
      end
      wv = ($urandom_range(0, 3) != 0);
      wr_valid = wv;
      wr_data  = (i == 0) ? hdr : ((i <= R) ? data[i - 1] : 8'hEE);
      take = wv && wr_ready;
      cyc();
      n++;
      if (take) i++;
    end
    wr_valid = 1'b0;
    chk("load_timeout", 32'(n < 2000), 1);
    chk("load_bytes_taken", 32'(i), good ? R + 1 : 1);
    chk("load_err", 32'(err), good ? 0 : 1);
    cyc();
    cyc();
    chk("load_wr_ready_after", 32'(wr_ready), 0);
    chk("load_done_once", 32'(done_cnt - d0), 1);
    chk("load_we_pulses", 32'(we_cnt - w0), good ? R : 0);
    chk("load_all_writes", 32'(exp_wr.size()), 0);
    if (good) begin
      for (int k = 0; k < R; k++) begin
        chk("load_mapper_reg", 32'(mreg[k]), 32'(data[k]));
        model_reg[k] = data[k];
      end
    end
    exp_wr.delete();
  endtask

  initial begin
    map_rst = 1'b1; cmd_save = 1'b0; cmd_load = 1'b0; map_idx = 8'd65;
    rd_ready = 1'b0; wr_data = 8'h00; wr_valid = 1'b0;
    for (int k = 0; k < R; k++) begin
      mreg[k]      = 8'hA0 + 8'(k);
      model_reg[k] = 8'hA0 + 8'(k);
    end
    repeat (3) cyc();
    #2;
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_done0", 32'(done), 0);
    chk("rst_err0", 32'(err), 0);
    chk("rst_act0", 32'(sst_act), 0);
    chk("rst_we0", 32'(sst_we_reg), 0);
    chk("rst_addr0", 32'(sst_addr), 0);
    chk("rst_dato0", 32'(sst_dato), 0);
    chk("rst_rd_data0", 32'(rd_data), 0);
    chk("rst_rd_valid0", 32'(rd_valid), 0);
    chk("rst_wr_ready0", 32'(wr_ready), 0);
    cyc();
    map_rst = 1'b0;

    run_save(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_first_byte", 32'(got_sv[0]), 32'h A0);
    chk("lit_reg15_byte", 32'(got_sv[15]), 32'h AF);
    chk("lit_idx_byte", 32'(got_sv[16]), 32'h41);

    run_save(1'b1, 1'b0, 1'b0, 1'b0);
    run_save(1'b0, 1'b1, 1'b1, 1'b1);

    run_load(8'h41, 1'b0, -1);
    for (int k = 0; k < R; k++) chk("lit_loaded_reg", 32'(mreg[k]), 32'(k));

    run_load(8'h42, 1'b0, -1);
    chk("lit_err_set", 32'(err), 1);
    run_save(1'b0, 1'b0, 1'b0, 1'b1);

    run_load(8'h41, 1'b1, 4);
    run_save(1'b0, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      map_idx = 8'($urandom_range(0, 255));
      run_load(map_idx, 1'b1, -1);
      run_save(1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
